// File: rtl/multicycle_cpu_if.sv
// Host-side bundle of the multi-cycle core: program-load port, debug register read and status.
interface multicycle_cpu_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              initialize;
  logic [31:0]       instruction_initialize_data;
  logic [31:0]       instruction_initialize_address;
  logic [REG_AW-1:0] dbg_reg_addr;
  logic [DATA_W-1:0] dbg_reg_data;
  logic [31:0]       pc_out;
  logic              halted;
  logic              illegal;
  logic              retire;
  logic [31:0]       retired_count;

  modport master (
    output initialize, instruction_initialize_data, instruction_initialize_address, dbg_reg_addr,
    input  dbg_reg_data, pc_out, halted, illegal, retire, retired_count
  );

  modport slave (
    input  initialize, instruction_initialize_data, instruction_initialize_address, dbg_reg_addr,
    output dbg_reg_data, pc_out, halted, illegal, retire, retired_count
  );
endinterface

// File: rtl/multicycle_cpu.sv
// Multi-cycle MIPS-subset core: one FSM walks FETCH/DECODE/EXEC/MEM/WB over internal
// instruction memory, data memory and register file, with HALT and illegal-opcode trapping.
module multicycle_cpu #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int IMEM_AW = 6,
  parameter int DMEM_AW = 6
) (
  input  logic            clk,
  input  logic            rst,
  multicycle_cpu_if.slave bus
);

  localparam int NREGS  = 2 ** REG_AW;
  localparam int IMEM_D = 2 ** IMEM_AW;
  localparam int DMEM_D = 2 ** DMEM_AW;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        ir_q, ir_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [DATA_W-1:0]  alu_q, alu_d;
  logic [DATA_W-1:0]  mdr_q, mdr_d;
  logic               halted_q, halted_d;
  logic               illegal_q, illegal_d;
  logic               retire_q, retire_d;
  logic [31:0]        retired_count_q, retired_count_d;

  logic [31:0]        imem [IMEM_D];
  logic [DATA_W-1:0]  dmem [DMEM_D];
  logic [DATA_W-1:0]  regs_q [NREGS];

  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [REG_AW-1:0]  rs, rt, rd;
  logic [DATA_W-1:0]  imm_ext;
  logic [DATA_W-1:0]  rf_a, rf_b;
  logic [DATA_W-1:0]  rtype_res;
  logic               funct_ok;
  logic [31:0]        branch_off;
  logic [31:0]        jump_target;
  logic [IMEM_AW-1:0] fetch_idx;
  logic [IMEM_AW-1:0] load_idx;
  logic [DMEM_AW-1:0] dmem_idx;

  logic               reg_we;
  logic [REG_AW-1:0]  reg_waddr;
  logic [DATA_W-1:0]  reg_wdata;
  logic               dmem_we;
  logic               unused_addr_bits;

  assign opcode      = ir_q[31:26];
  assign funct       = ir_q[5:0];
  assign rs          = ir_q[21 +: REG_AW];
  assign rt          = ir_q[16 +: REG_AW];
  assign rd          = ir_q[11 +: REG_AW];
  assign imm_ext     = DATA_W'($signed(ir_q[15:0]));
  assign branch_off  = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  assign jump_target = {pc_q[31:28], ir_q[25:0], 2'b00};
  assign fetch_idx   = pc_q[IMEM_AW+1:2];
  assign load_idx    = bus.instruction_initialize_address[IMEM_AW+1:2];
  assign dmem_idx    = alu_q[DMEM_AW+1:2];

  // Register 0 is hard-wired to zero on every read path.
  assign rf_a = (rs == '0) ? '0 : regs_q[rs];
  assign rf_b = (rt == '0) ? '0 : regs_q[rt];

  assign unused_addr_bits = ^{bus.instruction_initialize_address[31:IMEM_AW+2],
                              bus.instruction_initialize_address[1:0]};

  always_comb begin
    funct_ok  = 1'b1;
    rtype_res = '0;
    case (funct)
      FN_ADD:  rtype_res = a_q + b_q;
      FN_SUB:  rtype_res = a_q - b_q;
      FN_AND:  rtype_res = a_q & b_q;
      FN_OR:   rtype_res = a_q | b_q;
      FN_SLT:  rtype_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    ir_d            = ir_q;
    a_d             = a_q;
    b_d             = b_q;
    alu_d           = alu_q;
    mdr_d           = mdr_q;
    halted_d        = halted_q;
    illegal_d       = illegal_q;
    retire_d        = 1'b0;
    retired_count_d = retired_count_q;
    reg_we          = 1'b0;
    reg_waddr       = rt;
    reg_wdata       = alu_q;
    dmem_we         = 1'b0;

    // Program-load mode freezes the core at FETCH of address 0.
    if (bus.initialize) begin
      state_d   = S_FETCH;
      pc_d      = '0;
      halted_d  = 1'b0;
      illegal_d = 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          ir_d    = imem[fetch_idx];
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          a_d = rf_a;
          b_d = rf_b;
          case (opcode)
            OP_RTYPE: begin
              if (funct_ok) begin
                state_d = S_EXEC;
              end else begin
                state_d   = S_HALT;
                halted_d  = 1'b1;
                illegal_d = 1'b1;
              end
            end
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: state_d = S_EXEC;
            OP_HALT: begin
              state_d  = S_HALT;
              halted_d = 1'b1;
              retire_d = 1'b1;
            end
            default: begin
              state_d   = S_HALT;
              halted_d  = 1'b1;
              illegal_d = 1'b1;
            end
          endcase
        end
        S_EXEC: begin
          case (opcode)
            OP_RTYPE: begin
              alu_d   = rtype_res;
              state_d = S_WB;
            end
            OP_ADDI: begin
              alu_d   = a_q + imm_ext;
              state_d = S_WB;
            end
            OP_LW, OP_SW: begin
              alu_d   = a_q + imm_ext;
              state_d = S_MEM;
            end
            OP_BEQ, OP_BNE: begin
              if ((a_q == b_q) == (opcode == OP_BEQ)) pc_d = pc_q + branch_off;
              retire_d = 1'b1;
              state_d  = S_FETCH;
            end
            OP_J: begin
              pc_d     = jump_target;
              retire_d = 1'b1;
              state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
          endcase
        end
        S_MEM: begin
          if (opcode == OP_LW) begin
            mdr_d   = dmem[dmem_idx];
            state_d = S_WB;
          end else begin
            dmem_we  = 1'b1;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end
        end
        S_WB: begin
          reg_we    = 1'b1;
          reg_waddr = (opcode == OP_RTYPE) ? rd : rt;
          reg_wdata = (opcode == OP_LW) ? mdr_q : alu_q;
          retire_d  = 1'b1;
          state_d   = S_FETCH;
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_FETCH;
      endcase
    end

    if (retire_d) retired_count_d = retired_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= S_FETCH;
      pc_q            <= '0;
      ir_q            <= '0;
      a_q             <= '0;
      b_q             <= '0;
      alu_q           <= '0;
      mdr_q           <= '0;
      halted_q        <= 1'b0;
      illegal_q       <= 1'b0;
      retire_q        <= 1'b0;
      retired_count_q <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      ir_q            <= ir_d;
      a_q             <= a_d;
      b_q             <= b_d;
      alu_q           <= alu_d;
      mdr_q           <= mdr_d;
      halted_q        <= halted_d;
      illegal_q       <= illegal_d;
      retire_q        <= retire_d;
      retired_count_q <= retired_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (reg_we && (reg_waddr != '0)) begin
      regs_q[reg_waddr] <= reg_wdata;
    end
  end

  // Memories keep their contents across reset; reset only blocks writes.
  always_ff @(posedge clk) begin
    if (rst && bus.initialize) imem[load_idx] <= bus.instruction_initialize_data;
    if (rst && dmem_we)        dmem[dmem_idx] <= b_q;
  end

  assign bus.dbg_reg_data  = (bus.dbg_reg_addr == '0) ? '0 : regs_q[bus.dbg_reg_addr];
  assign bus.pc_out        = pc_q;
  assign bus.halted        = halted_q;
  assign bus.illegal       = illegal_q;
  assign bus.retire        = retire_q;
  assign bus.retired_count = retired_count_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Self-checking bench: directed and random programs run against an instruction-level model.
module tb_multicycle_cpu;
  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int IMEM_AW = 6;
  localparam int DMEM_AW = 6;
  localparam int IMEM_D  = 2 ** IMEM_AW;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_cpu_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  multicycle_cpu #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0]       prog    [IMEM_D];
  logic [DATA_W-1:0] m_regs  [2**REG_AW];
  logic [DATA_W-1:0] m_dmem  [2**DMEM_AW];
  logic [31:0]       m_pc;
  logic [31:0]       m_count;

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic fill_halt();
    for (int i = 0; i < IMEM_D; i++) prog[i] = HALT_W;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2**REG_AW; i++) m_regs[i] = '0;
    m_pc    = '0;
    m_count = '0;
  endtask

  // Instruction-set level model: executes one instruction and reports its cycle cost.
  task automatic model_step(output int lat, output bit is_halt, output bit is_ill, output int wreg);
    logic [31:0] ins, npc;
    logic [5:0]  op, fn;
    int rs, rt, rd;
    logic signed [DATA_W-1:0] va, vb, imm, res, addr;
    ins = prog[m_pc[IMEM_AW+1:2]];
    op = ins[31:26]; fn = ins[5:0];
    rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    va = m_regs[rs]; vb = m_regs[rt];
    imm = $signed(ins[15:0]);
    npc = m_pc + 32'd4;
    res = '0; lat = 2; is_halt = 0; is_ill = 0; wreg = -1;
    case (op)
      6'h00: begin
        lat = 4; wreg = rd;
        case (fn)
          6'h20: res = va + vb;
          6'h22: res = va - vb;
          6'h24: res = va & vb;
          6'h25: res = va | vb;
          6'h2A: res = (va < vb) ? 1 : 0;
          default: begin is_ill = 1; lat = 2; wreg = -1; end
        endcase
      end
      6'h08: begin lat = 4; wreg = rt; res = va + imm; end
      6'h23: begin
        lat = 5; wreg = rt; addr = va + imm;
        res = m_dmem[addr[DMEM_AW+1:2]];
      end
      6'h2B: begin
        lat = 4; addr = va + imm;
        m_dmem[addr[DMEM_AW+1:2]] = vb;
      end
      6'h04, 6'h05: begin
        lat = 3;
        if ((va == vb) == (op == 6'h04)) npc = npc + {{14{ins[15]}}, ins[15:0], 2'b00};
      end
      6'h02: begin lat = 3; npc = {npc[31:28], ins[25:0], 2'b00}; end
      6'h3F: begin lat = 2; is_halt = 1; end
      default: is_ill = 1;
    endcase
    if (!is_ill) m_count = m_count + 32'd1;
    if (wreg > 0) m_regs[wreg] = res;
    m_pc = npc;
  endtask

  task automatic load_program(input bit with_reset);
    @(negedge clk);
    if (with_reset) begin
      rst = 1'b0;
      bus.initialize = 1'b0;
      @(negedge clk);
      model_reset();
    end
    rst = 1'b1;
    bus.initialize = 1'b1;
    for (int i = 0; i < IMEM_D; i++) begin
      bus.instruction_initialize_address = 32'(i * 4);
      bus.instruction_initialize_data    = prog[i];
      @(negedge clk);
    end
    bus.initialize = 1'b0;
    m_pc = '0;
  endtask

  task automatic run_one(input string tag, output bit stop);
    int lat, wreg, cyc;
    bit is_halt, is_ill;
    logic [31:0] ins;
    logic exp_ret;
    ins = prog[m_pc[IMEM_AW+1:2]];
    model_step(lat, is_halt, is_ill, wreg);
    exp_ret = !is_ill;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (bus.retire !== 1'b1 && bus.halted !== 1'b1 && cyc < 12);
    n_cmp++;
    if (cyc != lat) begin
      n_fail++;
      $display("[TB] FAIL %s latency instr=%h: got %0d cycles, expected %0d", tag, ins, cyc, lat);
    end
    n_cmp++;
    if (bus.retire !== exp_ret) begin
      n_fail++;
      $display("[TB] FAIL %s retire instr=%h: got %b, expected %b", tag, ins, bus.retire, exp_ret);
    end
    n_cmp++;
    if (bus.pc_out !== m_pc) begin
      n_fail++;
      $display("[TB] FAIL %s pc instr=%h: got %h, expected %h", tag, ins, bus.pc_out, m_pc);
    end
    n_cmp++;
    if (bus.retired_count !== m_count) begin
      n_fail++;
      $display("[TB] FAIL %s retired_count: got %0d, expected %0d", tag, bus.retired_count, m_count);
    end
    n_cmp++;
    if (bus.halted !== (is_halt || is_ill) || bus.illegal !== is_ill) begin
      n_fail++;
      $display("[TB] FAIL %s halted/illegal: got %b/%b, expected %b/%b", tag, bus.halted, bus.illegal,
               (is_halt || is_ill), is_ill);
    end
    if (wreg >= 0) begin
      bus.dbg_reg_addr = REG_AW'(wreg);
      #1;
      n_cmp++;
      if (bus.dbg_reg_data !== m_regs[wreg]) begin
        n_fail++;
        $display("[TB] FAIL %s r%0d writeback: got %h, expected %h", tag, wreg, bus.dbg_reg_data, m_regs[wreg]);
      end
    end
    stop = is_halt || is_ill;
  endtask

  task automatic run_program(input string tag, input int max_instr);
    bit stop;
    int n;
    stop = 0;
    n = 0;
    while (!stop && n < max_instr) begin
      run_one(tag, stop);
      n++;
    end
    n_cmp++;
    if (!stop) begin
      n_fail++;
      $display("[TB] FAIL %s halt reached: got none in %0d instrs, expected halt", tag, max_instr);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.retire !== 1'b0 || bus.pc_out !== m_pc || bus.halted !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL %s after halt: retire=%b pc=%h halted=%b, expected 0/%h/1", tag, bus.retire,
               bus.pc_out, bus.halted, m_pc);
    end
    for (int r = 0; r < 2**REG_AW; r++) begin
      bus.dbg_reg_addr = REG_AW'(r);
      #1;
      n_cmp++;
      if (bus.dbg_reg_data !== m_regs[r]) begin
        n_fail++;
        $display("[TB] FAIL %s final r%0d: got %h, expected %h", tag, r, bus.dbg_reg_data, m_regs[r]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.initialize = 1'b1;
    bus.instruction_initialize_address = '0;
    bus.instruction_initialize_data = '0;
    bus.dbg_reg_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.pc_out !== 32'd0 || bus.halted !== 1'b0 || bus.illegal !== 1'b0 || bus.retire !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset status: got pc=%h h=%b i=%b r=%b, expected 0/0/0/0", bus.pc_out,
               bus.halted, bus.illegal, bus.retire);
    end
    n_cmp++;
    if (bus.retired_count !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL reset retired_count: got %0d, expected 0", bus.retired_count);
    end
    for (int r = 0; r < 2**REG_AW; r++) begin
      bus.dbg_reg_addr = REG_AW'(r);
      #1;
      n_cmp++;
      if (bus.dbg_reg_data !== '0) begin
        n_fail++;
        $display("[TB] FAIL reset r%0d: got %h, expected 0", r, bus.dbg_reg_data);
      end
    end
    @(negedge clk);
    bus.initialize = 1'b0;
    model_reset();
  endtask

  task automatic test_arith();
    fill_halt();
    prog[0] = enc_i(6'h08, 0, 1, 5);
    prog[1] = enc_i(6'h08, 0, 2, 7);
    prog[2] = enc_r(1, 2, 3, 6'h20);
    load_program(1'b1);
    run_program("arith", 10);
    bus.dbg_reg_addr = 5'd3;
    #1;
    n_cmp++;
    if (bus.dbg_reg_data !== DATA_W'(12) || bus.retired_count !== 32'd4) begin
      n_fail++;
      $display("[TB] FAIL arith result: got r3=%0d count=%0d, expected 12/4", bus.dbg_reg_data, bus.retired_count);
    end
  endtask

  task automatic test_mem();
    fill_halt();
    prog[0] = enc_i(6'h08, 0, 3, 16'h005A);
    prog[1] = enc_i(6'h2B, 0, 3, 8);
    prog[2] = enc_i(6'h23, 0, 4, 8);
    load_program(1'b1);
    run_program("mem", 10);
    bus.dbg_reg_addr = 5'd4;
    #1;
    n_cmp++;
    if (bus.dbg_reg_data !== DATA_W'(16'h005A)) begin
      n_fail++;
      $display("[TB] FAIL mem lw value: got %h, expected 5a", bus.dbg_reg_data);
    end
  endtask

  task automatic test_branch();
    fill_halt();
    prog[0]  = enc_i(6'h08, 0, 1, 3);
    prog[1]  = enc_i(6'h04, 1, 1, 1);
    prog[2]  = enc_i(6'h08, 0, 2, 99);
    prog[3]  = enc_i(6'h05, 1, 1, 1);
    prog[4]  = enc_i(6'h08, 0, 5, 1);
    prog[5]  = {6'h02, 26'h10};
    prog[6]  = enc_i(6'h08, 0, 6, 77);
    prog[16] = enc_i(6'h08, 0, 7, 5);
    load_program(1'b1);
    run_program("branch", 12);
    bus.dbg_reg_addr = 5'd2;
    #1;
    n_cmp++;
    if (bus.dbg_reg_data !== '0) begin
      n_fail++;
      $display("[TB] FAIL branch skipped instr: got r2=%0d, expected 0", bus.dbg_reg_data);
    end
  endtask

  task automatic test_slt_r0();
    fill_halt();
    prog[0] = enc_i(6'h08, 0, 1, -1);
    prog[1] = enc_i(6'h08, 0, 2, 1);
    prog[2] = enc_r(1, 2, 3, 6'h2A);
    prog[3] = enc_r(2, 1, 4, 6'h2A);
    prog[4] = enc_i(6'h08, 0, 0, 9);
    prog[5] = enc_r(2, 1, 5, 6'h22);
    prog[6] = enc_r(1, 2, 6, 6'h24);
    prog[7] = enc_r(1, 2, 7, 6'h25);
    load_program(1'b1);
    run_program("slt_r0", 12);
    bus.dbg_reg_addr = 5'd3;
    #1;
    n_cmp++;
    if (bus.dbg_reg_data !== DATA_W'(1)) begin
      n_fail++;
      $display("[TB] FAIL slt signed: got %0d, expected 1", bus.dbg_reg_data);
    end
    bus.dbg_reg_addr = 5'd0;
    #1;
    n_cmp++;
    if (bus.dbg_reg_data !== '0) begin
      n_fail++;
      $display("[TB] FAIL r0 write: got %h, expected 0", bus.dbg_reg_data);
    end
  endtask

  task automatic test_illegal();
    fill_halt();
    prog[0] = enc_i(6'h08, 0, 1, 4);
    prog[1] = 32'h4400_0000;
    prog[2] = enc_i(6'h08, 0, 2, 8);
    load_program(1'b1);
    run_program("illegal_op", 10);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.pc_out !== 32'h8 || bus.illegal !== 1'b1 || bus.retired_count !== 32'd1) begin
      n_fail++;
      $display("[TB] FAIL illegal hold: got pc=%h ill=%b count=%0d, expected 8/1/1", bus.pc_out,
               bus.illegal, bus.retired_count);
    end
    fill_halt();
    prog[0] = enc_i(6'h08, 1, 1, 4);
    prog[1] = enc_r(1, 1, 2, 6'h21);
    load_program(1'b0);
    n_cmp++;
    if (bus.halted !== 1'b0 || bus.illegal !== 1'b0 || bus.pc_out !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL initialize clear: got h=%b i=%b pc=%h, expected 0/0/0", bus.halted,
               bus.illegal, bus.pc_out);
    end
    run_program("illegal_funct", 10);
  endtask

  task automatic test_reset_mid_lw();
    bit stop;
    fill_halt();
    prog[0] = enc_i(6'h08, 0, 1, 7);
    prog[1] = enc_i(6'h2B, 0, 1, 4);
    prog[2] = enc_i(6'h23, 0, 2, 4);
    prog[3] = enc_r(2, 1, 3, 6'h20);
    load_program(1'b1);
    run_one("mid_lw", stop);
    run_one("mid_lw", stop);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.dbg_reg_addr = 5'd1;
    @(negedge clk);
    n_cmp++;
    if (bus.pc_out !== 32'd0 || bus.retired_count !== 32'd0 || bus.retire !== 1'b0 || bus.dbg_reg_data !== '0) begin
      n_fail++;
      $display("[TB] FAIL mid_lw reset: got pc=%h count=%0d retire=%b r1=%h, expected 0/0/0/0",
               bus.pc_out, bus.retired_count, bus.retire, bus.dbg_reg_data);
    end
    rst = 1'b1;
    model_reset();
    run_program("mid_lw_rerun", 10);
  endtask

  task automatic test_random();
    fill_halt();
    prog[0] = enc_i(6'h08, 0, 2, 256);
    prog[1] = enc_i(6'h2B, 1, 0, 0);
    prog[2] = enc_i(6'h08, 1, 1, 4);
    prog[3] = enc_i(6'h05, 1, 2, -3);
    load_program(1'b1);
    run_program("dmem_clear", 400);
    for (int p = 0; p < 5; p++) begin
      fill_halt();
      for (int i = 0; i < 24; i++) begin
        int kind, a, b, c;
        kind = int'($urandom_range(0, 7));
        a = int'($urandom_range(0, 7));
        b = int'($urandom_range(0, 7));
        c = int'($urandom_range(0, 7));
        case (kind)
          0:       prog[i] = enc_i(6'h08, a, b, int'($urandom_range(0, 400)) - 200);
          1, 2: begin
            logic [5:0] fns [5];
            fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
            prog[i] = enc_r(a, b, c, fns[$urandom_range(0, 4)]);
          end
          3:       prog[i] = enc_i(6'h2B, 0, b, 4 * int'($urandom_range(0, 63)));
          4:       prog[i] = enc_i(6'h23, 0, b, 4 * int'($urandom_range(0, 63)));
          5:       prog[i] = enc_i(6'h04, a, b, int'($urandom_range(0, 2)));
          6:       prog[i] = enc_i(6'h05, a, b, int'($urandom_range(0, 2)));
          default: prog[i] = enc_i(6'h08, a, b, int'($urandom_range(0, 65535)));
        endcase
      end
      load_program(1'b1);
      run_program("random", 40);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish by 500us, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_arith();
    test_mem();
    test_branch();
    test_slt_r0();
    test_illegal();
    test_reset_mid_lw();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
